// File: rtl/decode_hazard_ctrl_if.sv
// Decode-stage control bundle: ID instruction fields and redirect in, stall/flush/forward controls out.
// id_stall holds the current IF/ID instruction and PC; ex_redirect overrides it and flushes ID.
interface decode_hazard_ctrl_if;
  logic        if_valid;
  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        ex_redirect;
  logic        id_valid;
  logic        id_stall;
  logic        ex_bubble;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_count;

  modport master (
    output if_valid, opcode, rs1, rs2, rd, ex_redirect,
    input  id_valid, id_stall, ex_bubble, fwd_a, fwd_b, stall_count
  );

  modport slave (
    input  if_valid, opcode, rs1, rs2, rd, ex_redirect,
    output id_valid, id_stall, ex_bubble, fwd_a, fwd_b, stall_count
  );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard control: shadow EX/MEM/WB destination state, load-use stall,
// redirect flush, IF/ID valid tracking and EX operand forwarding selects.
module decode_hazard_ctrl (
  input logic                clk,
  input logic                rst_n,
  decode_hazard_ctrl_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
  } ex_entry_t;

  // Load-ness only matters while the producer sits in EX, so MEM/WB keep just the destination.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
  } dst_entry_t;

  ex_entry_t  ex_q;
  ex_entry_t  ex_next;
  dst_entry_t mem_q;
  dst_entry_t wb_q;

  logic        id_valid_q;
  logic [15:0] stall_count_q;

  logic use1;
  logic use2;
  logic writes;
  logic is_load;
  logic wen;
  logic load_use;
  logic id_stall;
  logic ex_bubble;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  always_comb begin
    use1    = 1'b0;
    use2    = 1'b0;
    writes  = 1'b0;
    is_load = 1'b0;
    case (bus.opcode)
      OPC_OP: begin
        use1   = 1'b1;
        use2   = 1'b1;
        writes = 1'b1;
      end
      OPC_OP_IMM, OPC_JALR: begin
        use1   = 1'b1;
        writes = 1'b1;
      end
      OPC_LOAD: begin
        use1    = 1'b1;
        writes  = 1'b1;
        is_load = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      OPC_JAL, OPC_LUI, OPC_AUIPC: begin
        writes = 1'b1;
      end
      default: begin
        use1    = 1'b0;
        use2    = 1'b0;
        writes  = 1'b0;
        is_load = 1'b0;
      end
    endcase
  end

  // x0 is never a destination, which keeps it out of both stall and forwarding paths.
  assign wen = writes && (bus.rd != 5'd0);

  always_comb begin
    ex_next.valid   = 1'b1;
    ex_next.rd      = bus.rd;
    ex_next.wen     = wen;
    ex_next.is_load = is_load;
    ex_next.rs1     = bus.rs1;
    ex_next.rs2     = bus.rs2;
    ex_next.use1    = use1;
    ex_next.use2    = use2;
  end

  always_comb begin
    load_use = id_valid_q && ex_q.valid && ex_q.is_load && ex_q.wen &&
               ((use1 && (ex_q.rd == bus.rs1)) || (use2 && (ex_q.rd == bus.rs2)));
    // A redirect kills the ID instruction anyway, so it must not also freeze the PC.
    id_stall  = load_use && !bus.ex_redirect;
    ex_bubble = id_stall || bus.ex_redirect || !id_valid_q;
  end

  always_comb begin
    fwd_a = FWD_RF;
    if (mem_q.valid && mem_q.wen && ex_q.use1 && (mem_q.rd == ex_q.rs1))
      fwd_a = FWD_MEM;
    else if (wb_q.valid && wb_q.wen && ex_q.use1 && (wb_q.rd == ex_q.rs1))
      fwd_a = FWD_WB;

    fwd_b = FWD_RF;
    if (mem_q.valid && mem_q.wen && ex_q.use2 && (mem_q.rd == ex_q.rs2))
      fwd_b = FWD_MEM;
    else if (wb_q.valid && wb_q.wen && ex_q.use2 && (wb_q.rd == ex_q.rs2))
      fwd_b = FWD_WB;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      id_valid_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      mem_q.valid <= ex_q.valid;
      mem_q.rd    <= ex_q.rd;
      mem_q.wen   <= ex_q.wen;
      wb_q        <= mem_q;
      ex_q        <= ex_bubble ? '0 : ex_next;

      if (bus.ex_redirect)
        id_valid_q <= 1'b0;
      else if (!id_stall)
        id_valid_q <= bus.if_valid;

      if (id_stall && (stall_count_q != COUNT_MAX))
        stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign bus.id_valid    = id_valid_q;
  assign bus.id_stall    = id_stall;
  assign bus.ex_bubble   = ex_bubble;
  assign bus.fwd_a       = fwd_a;
  assign bus.fwd_b       = fwd_b;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Bench for decode_hazard_ctrl: directed pipeline scenarios, randomized instruction streams and
// stall-counter saturation, all checked against an in-flight instruction list model.
module tb_decode_hazard_ctrl;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] NOP    = 7'b0000000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_hazard_ctrl_if bus ();

  decode_hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  // dest/src are register numbers, -1 when the instruction has no such register.
  typedef struct {
    bit live;
    bit load;
    int dest;
    int src_a;
    int src_b;
  } flight_t;

  flight_t pipe[$];
  bit      m_id_valid;
  int      m_count;

  logic       obs_stall;
  logic       obs_bubble;
  logic [1:0] obs_fwd_a;
  logic [1:0] obs_fwd_b;
  logic       obs_id_valid;
  logic [15:0] obs_count;

  function automatic flight_t dead();
    flight_t f;
    f.live = 0; f.load = 0; f.dest = -1; f.src_a = -1; f.src_b = -1;
    return f;
  endfunction

  function automatic flight_t describe(input logic [6:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] d);
    flight_t f;
    f = dead();
    f.live = 1;
    case (op)
      OP:            begin f.src_a = int'(a); f.src_b = int'(b); f.dest = int'(d); end
      OP_IMM, JALR:  begin f.src_a = int'(a); f.dest = int'(d); end
      LOAD:          begin f.src_a = int'(a); f.dest = int'(d); f.load = 1; end
      STORE, BRANCH: begin f.src_a = int'(a); f.src_b = int'(b); end
      JAL, LUI, AUIPC: f.dest = int'(d);
      default: ;
    endcase
    if (f.dest == 0) f.dest = -1;
    return f;
  endfunction

  function automatic logic [1:0] model_fwd(input int src);
    if (!pipe[0].live || src < 0) return 2'd0;
    if (pipe[1].live && pipe[1].dest == src) return 2'd1;
    if (pipe[2].live && pipe[2].dest == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    pipe.delete();
    repeat (3) pipe.push_back(dead());
    m_id_valid = 0;
    m_count    = 0;
  endtask

  // driver: one cycle with the given ID fields; checks outputs, then advances the model
  task automatic step(input logic rst, input logic iv, input logic [6:0] op, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] d, input logic redir);
    flight_t cur;
    bit hazard, e_stall, e_bubble;
    logic [1:0] e_fa, e_fb;
    @(negedge clk);
    rst_n           = rst;
    bus.if_valid    = iv;
    bus.opcode      = op;
    bus.rs1         = a;
    bus.rs2         = b;
    bus.rd          = d;
    bus.ex_redirect = redir;
    #1;
    cur      = describe(op, a, b, d);
    hazard   = m_id_valid && pipe[0].live && pipe[0].load && pipe[0].dest >= 0 &&
               (cur.src_a == pipe[0].dest || cur.src_b == pipe[0].dest);
    e_stall  = hazard && !redir;
    e_bubble = e_stall || redir || !m_id_valid;
    e_fa     = model_fwd(pipe[0].src_a);
    e_fb     = model_fwd(pipe[0].src_b);
    obs_stall    = bus.id_stall;
    obs_bubble   = bus.ex_bubble;
    obs_fwd_a    = bus.fwd_a;
    obs_fwd_b    = bus.fwd_b;
    obs_id_valid = bus.id_valid;
    obs_count    = bus.stall_count;
    check_eq("id_valid", obs_id_valid, m_id_valid);
    check_eq("id_stall", obs_stall, e_stall);
    check_eq("ex_bubble", obs_bubble, e_bubble);
    check_eq("fwd_a", obs_fwd_a, e_fa);
    check_eq("fwd_b", obs_fwd_b, e_fb);
    check_eq("stall_count", obs_count, m_count);
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      void'(pipe.pop_back());
      pipe.push_front(e_bubble ? dead() : cur);
      if (redir) m_id_valid = 0;
      else if (!e_stall) m_id_valid = iv;
      if (e_stall && m_count < 65535) m_count++;
    end
  endtask

  logic [6:0] op_tab [10];

  initial begin
    int count_before;
    op_tab = '{OP, OP_IMM, LOAD, LOAD, STORE, BRANCH, JALR, JAL, LUI, AUIPC};
    rst_n = 1'b0;
    bus.if_valid = 1'b0; bus.opcode = NOP; bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0;
    bus.ex_redirect = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // reset / idle
    step(1, 0, NOP, 0, 0, 0, 0);
    check_eq("rst_id_valid", obs_id_valid, 0);
    check_eq("rst_bubble", obs_bubble, 1);
    check_eq("rst_fwd_a", obs_fwd_a, 0);
    check_eq("rst_fwd_b", obs_fwd_b, 0);
    check_eq("rst_count", obs_count, 0);

    // LOAD x5 then dependent OP: one stall, then WB forwarding on operand A
    step(1, 1, NOP, 0, 0, 0, 0);
    step(1, 1, LOAD, 1, 0, 5, 0);
    check_eq("ld_no_stall", obs_stall, 0);
    step(1, 1, OP, 5, 6, 7, 0);
    check_eq("lu_stall", obs_stall, 1);
    step(1, 1, OP, 5, 6, 7, 0);
    check_eq("lu_stall_once", obs_stall, 0);
    check_eq("lu_count", obs_count, 1);
    step(1, 1, NOP, 0, 0, 0, 0);
    check_eq("lu_fwd_a_wb", obs_fwd_a, 2);
    check_eq("lu_fwd_b_rf", obs_fwd_b, 0);

    // two producers of x3: MEM beats WB
    step(1, 1, OP, 1, 2, 3, 0);
    step(1, 1, OP_IMM, 1, 0, 3, 0);
    step(1, 1, OP, 3, 3, 4, 0);
    check_eq("prio_no_stall", obs_stall, 0);
    step(1, 1, NOP, 0, 0, 0, 0);
    check_eq("prio_fwd_a_mem", obs_fwd_a, 1);
    check_eq("prio_fwd_b_mem", obs_fwd_b, 1);

    // x0 never stalls or forwards
    step(1, 1, LOAD, 1, 0, 0, 0);
    step(1, 1, OP, 0, 0, 8, 0);
    check_eq("x0_no_stall", obs_stall, 0);
    step(1, 1, NOP, 0, 0, 0, 0);
    check_eq("x0_fwd_a", obs_fwd_a, 0);

    // redirect suppresses a load-use stall
    step(1, 1, LOAD, 1, 0, 5, 0);
    count_before = int'(obs_count);
    step(1, 1, OP, 5, 6, 7, 1);
    check_eq("redir_no_stall", obs_stall, 0);
    step(1, 1, NOP, 0, 0, 0, 0);
    check_eq("redir_id_valid", obs_id_valid, 0);
    check_eq("redir_count", obs_count, count_before);
    check_eq("redir_bubble", obs_bubble, 1);

    // randomized instruction stream
    for (int i = 0; i < 4000; i++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 10) == 10) ? 7'($urandom_range(0, 127)) : op_tab[$urandom_range(0, 9)];
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 9) != 0), op,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 9) == 0));
    end

    // counter saturation
    step(0, 0, NOP, 0, 0, 0, 0);
    step(1, 1, NOP, 0, 0, 0, 0);
    for (int i = 0; i < 65537; i++) begin
      step(1, 1, LOAD, 1, 0, 5, 0);
      step(1, 1, OP, 5, 6, 7, 0);
    end
    step(1, 1, NOP, 0, 0, 0, 0);
    check_eq("sat_count", obs_count, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, LOAD, 1, 0, 5, 0);
      step(1, 1, OP, 5, 6, 7, 0);
    end
    step(1, 1, NOP, 0, 0, 0, 0);
    check_eq("sat_hold", obs_count, 16'hFFFF);

    // reset during a stall cycle
    step(1, 1, LOAD, 1, 0, 5, 0);
    step(0, 1, OP, 5, 6, 7, 0);
    check_eq("rst_mid_stall", obs_stall, 1);
    step(1, 1, OP, 5, 6, 7, 0);
    check_eq("rst_mid_count", obs_count, 0);
    check_eq("rst_mid_id_valid", obs_id_valid, 0);
    check_eq("rst_mid_no_stall", obs_stall, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
